// File: rtl/mux_rr_arb.sv
// rtl/mux_rr_arb.sv - N-channel packet mux with round-robin / fixed-priority arbitration
// Single registered output stage; a multi-beat packet holds the grant until its last beat.
module mux_rr_arb #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  input  logic [N-1:0]         in_last,
  output logic [N-1:0]         in_ready,
  input  logic                 mode,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SEL_W-1:0]     out_sel,
  output logic                 out_last
);

  logic [SEL_W-1:0] ptr;
  logic             locked;
  logic [SEL_W-1:0] g;
  logic             g_valid;
  logic             load_en;
  logic             xfer;
  logic             found;
  int               idx;

  assign load_en = !out_valid || out_ready;

  // While locked, out_sel still names the channel whose packet is in flight.
  always_comb begin
    g       = '0;
    g_valid = 1'b0;
    found   = 1'b0;
    idx     = 0;
    if (locked) begin
      g       = out_sel;
      g_valid = in_valid[out_sel];
    end else if (mode) begin
      for (int i = 0; i < N; i++) begin
        if (!found && in_valid[i]) begin
          found = 1'b1;
          g     = SEL_W'(i);
        end
      end
      g_valid = found;
    end else begin
      for (int k = 0; k < N; k++) begin
        idx = int'(ptr) + k;
        if (idx >= N) idx = idx - N;
        if (!found && in_valid[idx]) begin
          found = 1'b1;
          g     = SEL_W'(idx);
        end
      end
      g_valid = found;
    end
  end

  always_comb begin
    in_ready = '0;
    if (rst_n && load_en && g_valid) in_ready[g] = 1'b1;
  end

  assign xfer = |in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      out_last  <= 1'b0;
      ptr       <= '0;
      locked    <= 1'b0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data[int'(g)*WIDTH +: WIDTH];
      out_sel   <= g;
      out_last  <= in_last[g];
      if (in_last[g]) begin
        locked <= 1'b0;
        ptr    <= (g == SEL_W'(N-1)) ? '0 : g + 1'b1;
      end else begin
        locked <= 1'b1;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_rr_arb.sv
// tb/tb_mux_rr_arb.sv - directed table-driven bench for mux_rr_arb
module tb_mux_rr_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_last;
  logic [3:0]  in_ready;
  logic        mode;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_sel;
  logic        out_last;

  int checks = 0;
  int failures = 0;

  mux_rr_arb #(.WIDTH(8), .N(4), .SEL_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .mode(mode), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_sel(out_sel), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       mode;
    logic [3:0] valid;
    logic [3:0] last;
    logic       ordy;
    logic [3:0] exp_rdy;
    logic       exp_ov;
    logic [1:0] exp_sel;
    logic [7:0] exp_data;
    logic       exp_last;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs, check the combinational grant, clock once, check the output register.
  task automatic run_vec(input string tag, input vec_t v);
    mode      = v.mode;
    in_valid  = v.valid;
    in_last   = v.last;
    out_ready = v.ordy;
    #1;
    chk({tag, " in_ready"}, 64'(in_ready), 64'(v.exp_rdy));
    @(posedge clk);
    #1;
    chk({tag, " out_valid"}, 64'(out_valid), 64'(v.exp_ov));
    if (v.exp_ov) begin
      chk({tag, " out_sel"},  64'(out_sel),  64'(v.exp_sel));
      chk({tag, " out_data"}, 64'(out_data), 64'(v.exp_data));
      chk({tag, " out_last"}, 64'(out_last), 64'(v.exp_last));
    end
  endtask

  function automatic vec_t mk(logic m, logic [3:0] v, logic [3:0] l, logic r,
                              logic [3:0] er, logic eov, logic [1:0] es,
                              logic [7:0] ed, logic el);
    vec_t t;
    t.mode = m; t.valid = v; t.last = l; t.ordy = r;
    t.exp_rdy = er; t.exp_ov = eov; t.exp_sel = es; t.exp_data = ed; t.exp_last = el;
    return t;
  endfunction

  vec_t tbl[12];

  initial begin
    // round-robin single beats, fixed priority, then a 3-beat packet on channel 2
    tbl[0]  = mk(0, 4'hF, 4'hF, 1, 4'b0001, 1, 0, 8'hA0, 1);
    tbl[1]  = mk(0, 4'hF, 4'hF, 1, 4'b0010, 1, 1, 8'hA1, 1);
    tbl[2]  = mk(0, 4'hF, 4'hF, 1, 4'b0100, 1, 2, 8'hA2, 1);
    tbl[3]  = mk(0, 4'hF, 4'hF, 1, 4'b1000, 1, 3, 8'hA3, 1);
    tbl[4]  = mk(0, 4'hF, 4'hF, 1, 4'b0001, 1, 0, 8'hA0, 1);
    tbl[5]  = mk(1, 4'hF, 4'hF, 1, 4'b0001, 1, 0, 8'hA0, 1);
    tbl[6]  = mk(1, 4'hF, 4'hF, 1, 4'b0001, 1, 0, 8'hA0, 1);
    tbl[7]  = mk(1, 4'hE, 4'hF, 1, 4'b0010, 1, 1, 8'hA1, 1);
    tbl[8]  = mk(0, 4'hF, 4'hB, 1, 4'b0100, 1, 2, 8'hA2, 0);
    tbl[9]  = mk(0, 4'hF, 4'hB, 1, 4'b0100, 1, 2, 8'hA2, 0);
    tbl[10] = mk(0, 4'hF, 4'hF, 1, 4'b0100, 1, 2, 8'hA2, 1);
    tbl[11] = mk(0, 4'hF, 4'hF, 1, 4'b1000, 1, 3, 8'hA3, 1);

    in_data = 32'hA3A2A1A0;
    in_valid = '0; in_last = '0; mode = 0; out_ready = 1;
    rst_n = 0;
    #2;
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset in_ready", 64'(in_ready), 64'd0);
    chk("reset out_data", 64'(out_data), 64'd0);
    #10 rst_n = 1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) run_vec($sformatf("tbl%0d", i), tbl[i]);

    // backpressure: load 0x5C from channel 0 (ptr=0), then stall 5 cycles
    in_data[7:0] = 8'h5C;
    run_vec("bp_load", mk(0, 4'b0001, 4'hF, 1, 4'b0001, 1, 0, 8'h5C, 1));
    in_data[7:0] = 8'hA0;
    for (int c = 0; c < 5; c++)
      run_vec($sformatf("bp_hold%0d", c), mk(0, 4'hF, 4'hF, 0, 4'b0000, 1, 0, 8'h5C, 1));
    run_vec("bp_rel1", mk(0, 4'hF, 4'hF, 1, 4'b0010, 1, 1, 8'hA1, 1));
    run_vec("bp_rel2", mk(0, 4'hF, 4'hF, 1, 4'b0100, 1, 2, 8'hA2, 1));
    run_vec("bp_rel3", mk(0, 4'hF, 4'hF, 1, 4'b1000, 1, 3, 8'hA3, 1));
    run_vec("drain",   mk(0, 4'h0, 4'h0, 1, 4'b0000, 0, 0, 8'h00, 0));
    run_vec("idle_ptr", mk(0, 4'hF, 4'hF, 1, 4'b0001, 1, 0, 8'hA0, 1));

    // asynchronous reset in the middle of a channel-1 packet
    run_vec("pk1_b1", mk(0, 4'b0010, 4'h0, 1, 4'b0010, 1, 1, 8'hA1, 0));
    run_vec("pk1_b2", mk(0, 4'hF, 4'h0, 1, 4'b0010, 1, 1, 8'hA1, 0));
    #2 rst_n = 0;
    #1;
    chk("async out_valid", 64'(out_valid), 64'd0);
    chk("async in_ready", 64'(in_ready), 64'd0);
    chk("async out_sel", 64'(out_sel), 64'd0);
    #2 rst_n = 1;
    run_vec("post_rst", mk(0, 4'hF, 4'hF, 1, 4'b0001, 1, 0, 8'hA0, 1));

    // lock on channel 3, starve it for 2 cycles (mode flipped meanwhile), then finish
    run_vec("lk3_b1", mk(0, 4'b1000, 4'h0, 1, 4'b1000, 1, 3, 8'hA3, 0));
    run_vec("lk3_gap1", mk(1, 4'b0111, 4'h0, 1, 4'b0000, 0, 0, 8'h00, 0));
    run_vec("lk3_gap2", mk(1, 4'b0111, 4'h0, 1, 4'b0000, 0, 0, 8'h00, 0));
    run_vec("lk3_end", mk(0, 4'hF, 4'hF, 1, 4'b1000, 1, 3, 8'hA3, 1));
    run_vec("wrap0", mk(0, 4'hF, 4'hF, 1, 4'b0001, 1, 0, 8'hA0, 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
